// File: rtl/izhikevich_scheduler_if.sv
// rtl/izhikevich_scheduler_if.sv - step control, state port, spike report and core drive bundle
// spike_vec exists only when IZH_SPIKE_VEC_EN is defined.
interface izhikevich_scheduler_if #(
    parameter int N           = 32,
    parameter int NUM_NEURONS = 8
);
    localparam int IDX_W = $clog2(NUM_NEURONS);

    logic             step_start;
    logic             busy;
    logic             step_done;
    logic [N-1:0]     v_th;
    logic [N-1:0]     i_in;
    logic [IDX_W-1:0] cur_idx;

    logic             init_we;
    logic [IDX_W-1:0] init_addr;
    logic [N-1:0]     init_v;
    logic [N-1:0]     init_w;

    logic [IDX_W-1:0] rd_addr;
    logic [N-1:0]     rd_v;
    logic [N-1:0]     rd_w;

    logic             spike_valid;
    logic [IDX_W-1:0] spike_idx;
`ifdef IZH_SPIKE_VEC_EN
    logic [NUM_NEURONS-1:0] spike_vec;
`endif

    logic             core_rst;
    logic             core_apply;
    logic [N-1:0]     core_v_init;
    logic [N-1:0]     core_w_init;
    logic [N-1:0]     core_i;
    logic [N-1:0]     core_voltage;
    logic [N-1:0]     core_w;

    modport master (
`ifdef IZH_SPIKE_VEC_EN
        input  spike_vec,
`endif
        output step_start, v_th, i_in, init_we, init_addr, init_v, init_w, rd_addr,
               core_voltage, core_w,
        input  busy, step_done, cur_idx, rd_v, rd_w, spike_valid, spike_idx,
               core_rst, core_apply, core_v_init, core_w_init, core_i
    );

    modport slave (
`ifdef IZH_SPIKE_VEC_EN
        output spike_vec,
`endif
        input  step_start, v_th, i_in, init_we, init_addr, init_v, init_w, rd_addr,
               core_voltage, core_w,
        output busy, step_done, cur_idx, rd_v, rd_w, spike_valid, spike_idx,
               core_rst, core_apply, core_v_init, core_w_init, core_i
    );
endinterface

// File: rtl/izhikevich_scheduler.sv
// rtl/izhikevich_scheduler.sv - time-multiplexes one izhikevich_core across NUM_NEURONS neurons
// Define IZH_SPIKE_VEC_EN to add the registered per-step spike_vec output.
module izhikevich_scheduler #(
    parameter int N           = 32,
    parameter int Q           = 16,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    izhikevich_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_FIRE,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    if (NUM_NEURONS < 2 || Q >= N) begin : g_cfg_check
        $error("izhikevich_scheduler: NUM_NEURONS must be >= 2 and Q < N");
    end

    state_t           r_state;
    logic [N-1:0]     r_v [NUM_NEURONS];
    logic [N-1:0]     r_w [NUM_NEURONS];
    logic [IDX_W-1:0] r_cur_idx;
    logic [N-1:0]     r_core_i;
    logic             r_core_rst;
    logic             r_core_apply;
    logic             r_busy;
    logic             r_step_done;
    logic             r_spike_valid;
    logic [IDX_W-1:0] r_spike_idx;
`ifdef IZH_SPIKE_VEC_EN
    logic [NUM_NEURONS-1:0] r_spike_vec;
`endif

    logic w_init_ok;
    logic w_rd_ok;
    logic w_spike;

    assign w_init_ok = (32'(bus.init_addr) < NUM_NEURONS);
    assign w_rd_ok   = (32'(bus.rd_addr) < NUM_NEURONS);
    // Compare uses the neuron's stored voltage, i.e. the value before this step's update.
    assign w_spike   = ($signed(r_v[r_cur_idx]) >= $signed(bus.v_th));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cur_idx     <= '0;
            r_core_i      <= '0;
            r_core_rst    <= 1'b0;
            r_core_apply  <= 1'b0;
            r_busy        <= 1'b0;
            r_step_done   <= 1'b0;
            r_spike_valid <= 1'b0;
            r_spike_idx   <= '0;
`ifdef IZH_SPIKE_VEC_EN
            r_spike_vec   <= '0;
`endif
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_v[k] <= '0;
                r_w[k] <= '0;
            end
        end else begin
            r_step_done   <= 1'b0;
            r_spike_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.init_we && w_init_ok) begin
                        r_v[bus.init_addr] <= bus.init_v;
                        r_w[bus.init_addr] <= bus.init_w;
                    end
                    if (bus.step_start) begin
                        r_cur_idx  <= '0;
                        r_busy     <= 1'b1;
                        r_core_rst <= 1'b1;
`ifdef IZH_SPIKE_VEC_EN
                        r_spike_vec <= '0;
`endif
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_core_i   <= bus.i_in;
                    r_core_rst <= 1'b0;
                    r_state    <= S_ARM;
                end
                S_ARM: begin
                    r_core_apply <= 1'b1;
                    r_state      <= S_FIRE;
                end
                S_FIRE: begin
                    // Registered here so the pulse lines up with this neuron's STORE cycle.
                    if (w_spike) begin
                        r_spike_valid <= 1'b1;
                        r_spike_idx   <= r_cur_idx;
`ifdef IZH_SPIKE_VEC_EN
                        r_spike_vec[r_cur_idx] <= 1'b1;
`endif
                    end
                    r_state <= S_STORE;
                end
                S_STORE: begin
                    r_v[r_cur_idx] <= bus.core_voltage;
                    r_w[r_cur_idx] <= bus.core_w;
                    r_core_apply   <= 1'b0;
                    if (r_cur_idx == LAST_IDX) begin
                        r_step_done <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cur_idx  <= r_cur_idx + 1'b1;
                        r_core_rst <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.step_done   = r_step_done;
    assign bus.cur_idx     = r_cur_idx;
    assign bus.spike_valid = r_spike_valid;
    assign bus.spike_idx   = r_spike_idx;
`ifdef IZH_SPIKE_VEC_EN
    assign bus.spike_vec   = r_spike_vec;
`endif
    assign bus.core_rst    = r_core_rst;
    assign bus.core_apply  = r_core_apply;
    assign bus.core_i      = r_core_i;
    assign bus.core_v_init = r_v[r_cur_idx];
    assign bus.core_w_init = r_w[r_cur_idx];
    assign bus.rd_v        = w_rd_ok ? r_v[bus.rd_addr] : '0;
    assign bus.rd_w        = w_rd_ok ? r_w[bus.rd_addr] : '0;
endmodule

// File: tb/tb_izhikevich_scheduler.sv
// tb/tb_izhikevich_scheduler.sv - randomized self-checking bench with a behavioural core and step model
module tb_izhikevich_scheduler;
    localparam int NN       = 8;
    localparam int DONE_CYC = 4 * NN + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #20 clk = ~clk;

    izhikevich_scheduler_if #(.N(32), .NUM_NEURONS(NN)) bus();

    izhikevich_scheduler #(.N(32), .Q(16), .NUM_NEURONS(NN), .IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in core: loads on rst, updates once on each rising apply.
    logic [31:0] c_v = '0;
    logic [31:0] c_w = '0;
    logic        c_prev_apply = 1'b0;
    always @(posedge clk) begin
        c_prev_apply <= bus.core_apply;
        if (bus.core_rst) begin
            c_v <= bus.core_v_init;
            c_w <= bus.core_w_init;
        end else if (bus.core_apply && !c_prev_apply) begin
            c_v <= c_v + bus.core_i + 32'h0000_8000;
            c_w <= c_w + bus.core_i - 32'h0001_0000;
        end
    end
    assign bus.core_voltage = c_v;
    assign bus.core_w       = c_w;

    logic [31:0]   m_v [NN];
    logic [31:0]   m_w [NN];
    logic [31:0]   cur_i [NN];
    logic [31:0]   vth;
    logic [NN-1:0] exp_vec;
    int            exp_spk_cyc[$];
    int            exp_spk_idx[$];
    int            obs_spk_cyc[$];
    int            obs_spk_idx[$];
    int            o_done_cyc;
    int            o_n_done;
    int            o_pat_err;
    int            inj_cyc  = 0;
    logic          start_wr = 1'b0;
    logic [2:0]    wr_addr  = '0;
    logic [31:0]   wr_v     = '0;
    logic [31:0]   wr_w     = '0;

    task automatic write_state(input int k, input logic [31:0] v, input logic [31:0] w);
        bus.init_we   = 1'b1;
        bus.init_addr = 3'(k);
        bus.init_v    = v;
        bus.init_w    = w;
        @(posedge clk); #1;
        bus.init_we = 1'b0;
        m_v[k] = v;
        m_w[k] = w;
    endtask

    // Expected outcome of one whole step: spikes on the old voltage, then the core update.
    task automatic model_step();
        exp_spk_cyc.delete();
        exp_spk_idx.delete();
        exp_vec = '0;
        for (int k = 0; k < NN; k++) begin
            if ($signed(m_v[k]) >= $signed(vth)) begin
                exp_spk_cyc.push_back(4 * k + 4);
                exp_spk_idx.push_back(k);
                exp_vec[k] = 1'b1;
            end
            m_v[k] = m_v[k] + cur_i[k] + 32'h0000_8000;
            m_w[k] = m_w[k] + cur_i[k] - 32'h0001_0000;
        end
    endtask

    task automatic run_step(input int abort_cyc);
        int prev_spk;
        int ph;
        int k;
        o_done_cyc = -1;
        o_n_done   = 0;
        o_pat_err  = 0;
        prev_spk   = 0;
        obs_spk_cyc.delete();
        obs_spk_idx.delete();
        bus.v_th       = vth;
        bus.step_start = 1'b1;
        if (start_wr) begin
            bus.init_we   = 1'b1;
            bus.init_addr = wr_addr;
            bus.init_v    = wr_v;
            bus.init_w    = wr_w;
        end
        @(posedge clk); #1;
        bus.step_start = 1'b0;
        bus.init_we    = 1'b0;
        for (int cyc = 1; cyc <= DONE_CYC + 1; cyc++) begin
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                return;
            end
            if (bus.step_done === 1'b1) begin
                o_n_done++;
                o_done_cyc = cyc;
            end
            if (bus.spike_valid === 1'b1) begin
                if (prev_spk != 0) o_pat_err++;
                obs_spk_cyc.push_back(cyc);
                obs_spk_idx.push_back(int'(bus.spike_idx));
            end
            prev_spk = (bus.spike_valid === 1'b1) ? 1 : 0;
            if (cyc < DONE_CYC) begin
                ph = (cyc - 1) % 4;
                k  = (cyc - 1) / 4;
                if (bus.core_rst !== (ph == 0)) o_pat_err++;
                if (bus.core_apply !== (ph >= 2)) o_pat_err++;
                if (int'(bus.cur_idx) != k) o_pat_err++;
                if (bus.busy !== 1'b1) o_pat_err++;
                if (ph >= 1 && bus.core_i !== cur_i[k]) o_pat_err++;
            end else if (cyc == DONE_CYC) begin
                if (bus.core_rst !== 1'b0 || bus.core_apply !== 1'b0) o_pat_err++;
                if (bus.busy !== 1'b1 || int'(bus.cur_idx) != NN - 1) o_pat_err++;
            end else begin
                if (bus.busy !== 1'b0 || bus.core_rst !== 1'b0 || bus.core_apply !== 1'b0) o_pat_err++;
            end
            bus.init_we    = (cyc == inj_cyc);
            bus.step_start = (cyc == inj_cyc);
            bus.init_addr  = wr_addr;
            bus.init_v     = wr_v;
            bus.init_w     = wr_w;
            bus.i_in       = cur_i[bus.cur_idx];
            if (cyc == DONE_CYC + 1) break;
            @(posedge clk); #1;
        end
        bus.init_we    = 1'b0;
        bus.step_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.step_done !== 1'b0) begin n_fail++; $display("FAIL reset_step_done: got %b want 0", bus.step_done); end
        n_tests++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL reset_spike_valid: got %b want 0", bus.spike_valid); end
        n_tests++; if ({bus.core_rst, bus.core_apply} !== 2'b00) begin n_fail++; $display("FAIL reset_core_ctl: got %b want 00", {bus.core_rst, bus.core_apply}); end
        n_tests++; if (bus.cur_idx !== 3'd0 || bus.core_i !== 32'd0) begin n_fail++; $display("FAIL reset_idx_i: got %0d/%h want 0/0", bus.cur_idx, bus.core_i); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NN; k++) begin
            bus.rd_addr = 3'(k); #1;
            n_tests++; if (bus.rd_v !== 32'd0 || bus.rd_w !== 32'd0) begin n_fail++; $display("FAIL reset_state[%0d]: got %h/%h want 0/0", k, bus.rd_v, bus.rd_w); end
            m_v[k] = '0; m_w[k] = '0; cur_i[k] = '0;
        end
`ifdef IZH_SPIKE_VEC_EN
        n_tests++; if (bus.spike_vec !== '0) begin n_fail++; $display("FAIL reset_spike_vec: got %h want 0", bus.spike_vec); end
`endif
    endtask

    task automatic test_no_spike();
        vth = 32'h001E_0000;
        for (int k = 0; k < NN; k++) begin
            write_state(k, 32'hFFBF_0000, 32'hFFF3_0000);
            cur_i[k] = '0;
        end
        model_step();
        run_step(0);
        n_tests++; if (o_done_cyc != DONE_CYC) begin n_fail++; $display("FAIL nospike_done_cycle: got %0d want %0d", o_done_cyc, DONE_CYC); end
        n_tests++; if (o_n_done != 1) begin n_fail++; $display("FAIL nospike_done_count: got %0d want 1", o_n_done); end
        n_tests++; if (o_pat_err != 0) begin n_fail++; $display("FAIL nospike_pattern: got %0d errors want 0", o_pat_err); end
        n_tests++; if (obs_spk_cyc.size() != 0) begin n_fail++; $display("FAIL nospike_spikes: got %0d want 0", obs_spk_cyc.size()); end
        for (int k = 0; k < NN; k++) begin
            bus.rd_addr = 3'(k); #1;
            n_tests++; if (bus.rd_v !== m_v[k] || bus.rd_w !== m_w[k]) begin n_fail++; $display("FAIL nospike_state[%0d]: got %h/%h want %h/%h", k, bus.rd_v, bus.rd_w, m_v[k], m_w[k]); end
        end
    endtask

    task automatic test_single_spike();
        for (int k = 0; k < NN; k++) write_state(k, 32'hFFBF_0000, 32'hFFF3_0000);
        write_state(3, 32'h0023_0000, 32'hFFF3_0000);
        model_step();
        run_step(0);
        n_tests++; if (obs_spk_cyc.size() != 1) begin n_fail++; $display("FAIL single_spike_count: got %0d want 1", obs_spk_cyc.size()); end
        else begin
            n_tests++; if (obs_spk_cyc[0] != 16 || obs_spk_idx[0] != 3) begin n_fail++; $display("FAIL single_spike_where: got cyc %0d idx %0d want cyc 16 idx 3", obs_spk_cyc[0], obs_spk_idx[0]); end
        end
        n_tests++; if (o_done_cyc != DONE_CYC || o_pat_err != 0) begin n_fail++; $display("FAIL single_spike_step: got done %0d err %0d want %0d/0", o_done_cyc, o_pat_err, DONE_CYC); end
`ifdef IZH_SPIKE_VEC_EN
        n_tests++; if (bus.spike_vec !== 8'h08) begin n_fail++; $display("FAIL single_spike_vec: got %h want 08", bus.spike_vec); end
`endif
    endtask

    task automatic test_current_ramp();
        for (int k = 0; k < NN; k++) cur_i[k] = 32'(k) << 16;
        model_step();
        run_step(0);
        n_tests++; if (o_pat_err != 0) begin n_fail++; $display("FAIL ramp_pattern_core_i: got %0d errors want 0", o_pat_err); end
        for (int k = 0; k < NN; k++) begin
            bus.rd_addr = 3'(k); #1;
            n_tests++; if (bus.rd_v !== m_v[k] || bus.rd_w !== m_w[k]) begin n_fail++; $display("FAIL ramp_state[%0d]: got %h/%h want %h/%h", k, bus.rd_v, bus.rd_w, m_v[k], m_w[k]); end
        end
    endtask

    task automatic test_ignore_in_step();
        inj_cyc = 6; wr_addr = 3'd5; wr_v = 32'h1234_5678; wr_w = 32'h0BAD_F00D;
        model_step();
        run_step(0);
        inj_cyc = 0;
        n_tests++; if (o_n_done != 1 || o_done_cyc != DONE_CYC) begin n_fail++; $display("FAIL ignore_done: got %0d pulses at %0d want 1 at %0d", o_n_done, o_done_cyc, DONE_CYC); end
        n_tests++; if (o_pat_err != 0) begin n_fail++; $display("FAIL ignore_pattern: got %0d errors want 0", o_pat_err); end
        bus.rd_addr = 3'd5; #1;
        n_tests++; if (bus.rd_v !== m_v[5] || bus.rd_w !== m_w[5]) begin n_fail++; $display("FAIL ignore_state5: got %h/%h want %h/%h", bus.rd_v, bus.rd_w, m_v[5], m_w[5]); end
    endtask

    task automatic test_write_with_start();
        start_wr = 1'b1; wr_addr = 3'd0; wr_v = 32'h0023_0000; wr_w = 32'h0001_0000;
        m_v[0] = wr_v; m_w[0] = wr_w;
        model_step();
        run_step(0);
        start_wr = 1'b0;
        n_tests++; if (obs_spk_cyc.size() < 1 || obs_spk_cyc[0] != 4 || obs_spk_idx[0] != 0) begin n_fail++; $display("FAIL wrstart_spike0: got %0d spikes want first at cyc 4 idx 0", obs_spk_cyc.size()); end
        bus.rd_addr = 3'd0; #1;
        n_tests++; if (bus.rd_v !== m_v[0] || bus.rd_w !== m_w[0]) begin n_fail++; $display("FAIL wrstart_state0: got %h/%h want %h/%h", bus.rd_v, bus.rd_w, m_v[0], m_w[0]); end
    endtask

    task automatic test_signed_boundary();
        vth = 32'hFFF0_0000;
        for (int k = 0; k < NN; k++) begin
            write_state(k, 32'hFFBF_0000, 32'(k));
            cur_i[k] = 32'(k * 3);
        end
        write_state(0, vth, 32'h0);
        write_state(1, vth - 32'd1, 32'h0);
        write_state(2, 32'h7FFF_FFFF, 32'h0);
        write_state(3, 32'h8000_0000, 32'h0);
        write_state(4, 32'h0000_0000, 32'h0);
        model_step();
        run_step(0);
        n_tests++; if (obs_spk_cyc.size() != exp_spk_cyc.size()) begin n_fail++; $display("FAIL signed_spike_count: got %0d want %0d", obs_spk_cyc.size(), exp_spk_cyc.size()); end
        else for (int j = 0; j < exp_spk_cyc.size(); j++) begin
            n_tests++; if (obs_spk_cyc[j] != exp_spk_cyc[j] || obs_spk_idx[j] != exp_spk_idx[j]) begin n_fail++; $display("FAIL signed_spike[%0d]: got cyc %0d idx %0d want cyc %0d idx %0d", j, obs_spk_cyc[j], obs_spk_idx[j], exp_spk_cyc[j], exp_spk_idx[j]); end
        end
`ifdef IZH_SPIKE_VEC_EN
        n_tests++; if (bus.spike_vec !== exp_vec) begin n_fail++; $display("FAIL signed_spike_vec: got %h want %h", bus.spike_vec, exp_vec); end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            vth = 32'($urandom_range(0, 32'h0040_0000)) - 32'h0020_0000;
            for (int k = 0; k < NN; k++) begin
                write_state(k, vth + 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000, 32'($urandom));
                cur_i[k] = 32'($urandom_range(0, 32'h000F_FFFF));
            end
            model_step();
            run_step(0);
            n_tests++; if (o_done_cyc != DONE_CYC || o_pat_err != 0) begin n_fail++; $display("FAIL random%0d_step: got done %0d err %0d want %0d/0", r, o_done_cyc, o_pat_err, DONE_CYC); end
            n_tests++; if (obs_spk_cyc.size() != exp_spk_cyc.size()) begin n_fail++; $display("FAIL random%0d_spike_count: got %0d want %0d", r, obs_spk_cyc.size(), exp_spk_cyc.size()); end
            else for (int j = 0; j < exp_spk_cyc.size(); j++) begin
                n_tests++; if (obs_spk_cyc[j] != exp_spk_cyc[j] || obs_spk_idx[j] != exp_spk_idx[j]) begin n_fail++; $display("FAIL random%0d_spike[%0d]: got cyc %0d idx %0d want cyc %0d idx %0d", r, j, obs_spk_cyc[j], obs_spk_idx[j], exp_spk_cyc[j], exp_spk_idx[j]); end
            end
            for (int k = 0; k < NN; k++) begin
                bus.rd_addr = 3'(k); #1;
                n_tests++; if (bus.rd_v !== m_v[k] || bus.rd_w !== m_w[k]) begin n_fail++; $display("FAIL random%0d_state[%0d]: got %h/%h want %h/%h", r, k, bus.rd_v, bus.rd_w, m_v[k], m_w[k]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            model_step();
            run_step(0);
            n_tests++; if (o_n_done != 1 || o_done_cyc != DONE_CYC || o_pat_err != 0) begin n_fail++; $display("FAIL b2b%0d: got %0d pulses at %0d err %0d want 1 at %0d err 0", s, o_n_done, o_done_cyc, o_pat_err, DONE_CYC); end
        end
        for (int k = 0; k < NN; k++) begin
            bus.rd_addr = 3'(k); #1;
            n_tests++; if (bus.rd_v !== m_v[k] || bus.rd_w !== m_w[k]) begin n_fail++; $display("FAIL b2b_state[%0d]: got %h/%h want %h/%h", k, bus.rd_v, bus.rd_w, m_v[k], m_w[k]); end
        end
    endtask

    task automatic test_reset_mid_step();
        int late_done;
        run_step(4 * 4 + 3);
        n_tests++; if ({bus.busy, bus.step_done, bus.spike_valid, bus.core_rst, bus.core_apply} !== 5'b0) begin n_fail++; $display("FAIL abort_outputs: got %b want 00000", {bus.busy, bus.step_done, bus.spike_valid, bus.core_rst, bus.core_apply}); end
        n_tests++; if (bus.cur_idx !== 3'd0 || bus.core_i !== 32'd0) begin n_fail++; $display("FAIL abort_idx_i: got %0d/%h want 0/0", bus.cur_idx, bus.core_i); end
        bus.rd_addr = 3'd2; #1;
        n_tests++; if (bus.rd_v !== 32'd0 || bus.rd_w !== 32'd0) begin n_fail++; $display("FAIL abort_state_cleared: got %h/%h want 0/0", bus.rd_v, bus.rd_w); end
        late_done = 0;
        repeat (2) begin @(posedge clk); #1; if (bus.step_done === 1'b1) late_done++; end
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (bus.step_done === 1'b1) late_done++; end
        n_tests++; if (late_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", late_done); end
        for (int k = 0; k < NN; k++) begin m_v[k] = '0; m_w[k] = '0; end
        vth = 32'h001E_0000;
        model_step();
        run_step(0);
        n_tests++; if (o_done_cyc != DONE_CYC || o_pat_err != 0 || obs_spk_cyc.size() != 0) begin n_fail++; $display("FAIL after_abort_step: got done %0d err %0d spikes %0d want %0d/0/0", o_done_cyc, o_pat_err, obs_spk_cyc.size(), DONE_CYC); end
        for (int k = 0; k < NN; k++) begin
            bus.rd_addr = 3'(k); #1;
            n_tests++; if (bus.rd_v !== m_v[k] || bus.rd_w !== m_w[k]) begin n_fail++; $display("FAIL after_abort_state[%0d]: got %h/%h want %h/%h", k, bus.rd_v, bus.rd_w, m_v[k], m_w[k]); end
        end
    endtask

    initial begin
        bus.step_start = 1'b0;
        bus.init_we    = 1'b0;
        bus.init_addr  = '0;
        bus.init_v     = '0;
        bus.init_w     = '0;
        bus.rd_addr    = '0;
        bus.i_in       = '0;
        bus.v_th       = '0;
        vth            = '0;
        test_reset();
        test_no_spike();
        test_single_spike();
        test_current_ramp();
        test_ignore_in_step();
        test_write_with_start();
        test_signed_boundary();
        test_random();
        test_back_to_back();
        test_reset_mid_step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
